// File: rtl/program_feeder.sv
// program_feeder: operator-loaded program buffer that replays one word per
// processor step. Words are captured from the switches in LOAD, presented on
// DATA_OUT in RUN, and PC advances only on steps where the processor consumed
// external data.
module program_feeder #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             CLK50M,
   input  logic             CLR,
   input  logic [WIDTH-1:0] SW_DATA,
   input  logic             LOAD_STB,
   input  logic             RUN_STB,
   input  logic             STEP_REQ,
   input  logic             EXT,
   input  logic             DONE,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             STEP_OUT,
   output logic [AW-1:0]    PC,
   output logic [AW:0]      COUNT,
   output logic [1:0]       STATE,
   output logic             FULL,
   output logic             EXHAUSTED,
   output logic             ERR
);

   localparam logic [1:0]  S_LOAD  = 2'b00;
   localparam logic [1:0]  S_RUN   = 2'b01;
   localparam logic [1:0]  S_HALT  = 2'b10;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [1:0]       state;
   logic [AW:0]      count;
   // pc is one bit wider than the PC port so that pc == count is
   // representable with a completely full buffer.
   logic [AW:0]      pc;
   logic [WIDTH-1:0] data_q;
   logic             step_q;
   logic             consume;
   logic             pend;
   logic             err_q;
   logic             full;
   logic             at_end;

   assign full      = (count == DEPTH_C);
   assign at_end    = (pc == count);

   assign DATA_OUT  = data_q;
   assign STEP_OUT  = step_q;
   assign PC        = pc[AW-1:0];
   assign COUNT     = count;
   assign STATE     = state;
   assign FULL      = full;
   assign EXHAUSTED = (state != S_LOAD) && at_end;
   assign ERR       = err_q;

   // Program buffer write port; contents survive CLR.
   always_ff @(posedge CLK50M) begin
      if (!CLR && state == S_LOAD && LOAD_STB && !full)
         mem[count[AW-1:0]] <= SW_DATA;
   end

   // Control FSM, step pulse generation, pointer and output register.
   always_ff @(posedge CLK50M) begin
      if (CLR) begin
         state   <= S_LOAD;
         count   <= '0;
         pc      <= '0;
         data_q  <= '0;
         step_q  <= 1'b0;
         consume <= 1'b0;
         pend    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // Output word trails PC by one cycle, so it is stable across the pulse.
         data_q <= (state != S_LOAD && !at_end) ? mem[pc[AW-1:0]] : '0;
         case (state)
            S_LOAD: begin
               if (LOAD_STB) begin
                  if (!full)
                     count <= count + 1'b1;
               end else if (RUN_STB && count != '0) begin
                  state <= S_RUN;
                  pc    <= '0;
               end
            end
            S_RUN: begin
               if (RUN_STB) begin
                  pc      <= '0;
                  step_q  <= 1'b0;
                  consume <= 1'b0;
                  pend    <= 1'b0;
               end else if (at_end && DONE) begin
                  state   <= S_HALT;
                  step_q  <= 1'b0;
                  consume <= 1'b0;
                  pend    <= 1'b0;
               end else if (step_q) begin
                  // End of pulse: advance only if the processor took the word.
                  step_q  <= 1'b0;
                  consume <= 1'b0;
                  if (consume) begin
                     if (!at_end) begin
                        pc   <= pc + 1'b1;
                        pend <= 1'b1;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end else if (pend) begin
                  pend <= 1'b0;
               end else if (STEP_REQ) begin
                  step_q  <= 1'b1;
                  consume <= EXT;
               end
            end
            S_HALT: begin
               if (LOAD_STB) begin
                  state <= S_LOAD;
                  count <= '0;
                  pc    <= '0;
               end else if (RUN_STB) begin
                  state <= S_RUN;
                  pc    <= '0;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_program_feeder.sv
// tb_program_feeder: directed stimulus for program_feeder with a reference
// model updated every clock and compared on every falling edge, plus literal
// spot checks at key points of the sequence.
module tb_program_feeder;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [9:0] sw = '0;
   logic       load = 1'b0, run = 1'b0, step = 1'b0, ext = 1'b0, done = 1'b0;
   logic [9:0] data_out;
   logic       step_out, full, exhausted, err;
   logic [3:0] pc;
   logic [4:0] count;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   program_feeder #(.WIDTH(10), .DEPTH(16), .AW(4)) dut (
      .CLK50M(clk), .CLR(clr), .SW_DATA(sw), .LOAD_STB(load), .RUN_STB(run),
      .STEP_REQ(step), .EXT(ext), .DONE(done), .DATA_OUT(data_out),
      .STEP_OUT(step_out), .PC(pc), .COUNT(count), .STATE(state),
      .FULL(full), .EXHAUSTED(exhausted), .ERR(err)
   );

   always #10 clk = ~clk;

   // Reference model: mode 0 LOAD, 1 RUN, 2 HALT; phase tracks a step in flight.
   logic [9:0] m_mem [16];
   int         m_mode = 0, m_cnt = 0, m_ptr = 0;
   bit         m_pulse = 0, m_cons = 0, m_settle = 0, m_err = 0, mvalid = 0;
   logic [9:0] m_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Advance the model on every rising edge from the inputs held during the cycle.
   always @(posedge clk) begin
      if (clr) begin
         mvalid = 1; m_mode = 0; m_cnt = 0; m_ptr = 0; m_data = '0;
         m_pulse = 0; m_cons = 0; m_settle = 0; m_err = 0;
      end else begin
         m_data = (m_mode != 0 && m_ptr != m_cnt) ? m_mem[m_ptr % 16] : 10'h000;
         case (m_mode)
            0: if (load) begin
                  if (m_cnt < 16) begin m_mem[m_cnt] = sw; m_cnt++; end
               end else if (run && m_cnt > 0) begin
                  m_mode = 1; m_ptr = 0;
               end
            1: if (run) begin
                  m_ptr = 0; m_pulse = 0; m_cons = 0; m_settle = 0;
               end else if (m_ptr == m_cnt && done) begin
                  m_mode = 2; m_pulse = 0; m_cons = 0; m_settle = 0;
               end else if (m_pulse) begin
                  m_pulse = 0;
                  if (m_cons) begin
                     if (m_ptr < m_cnt) begin m_ptr++; m_settle = 1; end
                     else m_err = 1;
                  end
                  m_cons = 0;
               end else if (m_settle) begin
                  m_settle = 0;
               end else if (step) begin
                  m_pulse = 1; m_cons = ext;
               end
            default: if (load) begin
                  m_mode = 0; m_cnt = 0; m_ptr = 0;
               end else if (run) begin
                  m_mode = 1; m_ptr = 0;
               end
         endcase
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (mvalid) begin
         check("DATA_OUT", 32'(data_out), 32'(m_data));
         check("STEP_OUT", 32'(step_out), 32'(m_pulse));
         check("PC", 32'(pc), 32'(m_ptr % 16));
         check("COUNT", 32'(count), 32'(m_cnt));
         check("STATE", 32'(state), 32'(m_mode));
         check("FULL", 32'(full), 32'(m_cnt == 16));
         check("EXHAUSTED", 32'(exhausted), 32'(m_mode != 0 && m_ptr == m_cnt));
         check("ERR", 32'(err), 32'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [9:0] v);
      sw = v; load = 1'b1; tick(); load = 1'b0;
   endtask

   task automatic consume(input int n);
      for (int i = 0; i < n; i++) begin
         step = 1'b1; ext = 1'b1; tick();
         step = 1'b0; ext = 1'b0; tick(); tick();
      end
   endtask

   initial begin
      clr = 1'b1; tick(); tick(); clr = 1'b0;
      check("rst_state", 32'(state), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_step", 32'(step_out), 32'd0);

      // Load three words; STEP_REQ ignored in LOAD.
      load_word(10'h040); load_word(10'h005); load_word(10'h123);
      check("load_count", 32'(count), 32'd3);
      check("load_full", 32'(full), 32'd0);
      check("load_data", 32'(data_out), 32'h000);
      step = 1'b1; tick(); step = 1'b0; tick();
      check("load_nostep", 32'(step_out), 32'd0);

      // Start replay and consume the first word.
      run = 1'b1; tick(); run = 1'b0;
      check("run_state", 32'(state), 32'd1);
      step = 1'b1; ext = 1'b1; tick(); step = 1'b0; ext = 1'b0;
      check("pulse_hi", 32'(step_out), 32'd1);
      check("pulse_data", 32'(data_out), 32'h040);
      tick();
      check("pc_adv", 32'(pc), 32'd1);
      check("data_hold", 32'(data_out), 32'h040);
      tick();
      check("data_next", 32'(data_out), 32'h005);

      // Non-consuming step with a duplicate request on the pulse cycle.
      step = 1'b1; tick();
      check("nc_pulse", 32'(step_out), 32'd1);
      tick(); step = 1'b0;
      check("nc_single", 32'(step_out), 32'd0);
      check("nc_pc", 32'(pc), 32'd1);
      tick();
      check("nc_nopulse", 32'(step_out), 32'd0);
      check("nc_data", 32'(data_out), 32'h005);
      done = 1'b1; tick(); done = 1'b0;
      check("early_done", 32'(state), 32'd1);

      // Exhaust, halt, and replay.
      consume(2);
      check("exh_pc", 32'(pc), 32'd3);
      check("exh_flag", 32'(exhausted), 32'd1);
      done = 1'b1; tick(); done = 1'b0;
      check("halt_state", 32'(state), 32'd2);
      step = 1'b1; tick(); step = 1'b0; tick();
      check("halt_nostep", 32'(step_out), 32'd0);
      run = 1'b1; tick(); run = 1'b0;
      check("replay_state", 32'(state), 32'd1);
      check("replay_pc", 32'(pc), 32'd0);
      tick();
      check("replay_data", 32'(data_out), 32'h040);

      // HALT with LOAD and RUN together returns to LOAD.
      consume(3);
      done = 1'b1; tick(); done = 1'b0;
      load = 1'b1; run = 1'b1; tick(); load = 1'b0; run = 1'b0;
      check("reload_state", 32'(state), 32'd0);
      check("reload_count", 32'(count), 32'd0);

      // Fill the buffer (RUN on the last load is ignored), then overflow.
      for (int i = 0; i < 16; i++) begin
         sw = 10'((i * 37 + 17) & 10'h3FF); load = 1'b1;
         if (i == 15) run = 1'b1;
         tick(); load = 1'b0; run = 1'b0;
      end
      check("fill_count", 32'(count), 32'd16);
      check("fill_state", 32'(state), 32'd0);
      load_word(10'h3FF);
      check("ovf_count", 32'(count), 32'd16);
      check("ovf_full", 32'(full), 32'd1);
      run = 1'b1; tick(); run = 1'b0; tick();
      check("mem0_kept", 32'(data_out), 32'h011);

      // Underflow after all 16 words consumed.
      consume(16);
      check("full_exh", 32'(exhausted), 32'd1);
      check("full_pc", 32'(pc), 32'd0);
      step = 1'b1; ext = 1'b1; tick(); step = 1'b0; ext = 1'b0;
      check("uf_pulse", 32'(step_out), 32'd1);
      check("uf_data", 32'(data_out), 32'h000);
      tick();
      check("uf_err", 32'(err), 32'd1);

      // CLR on the pulse cycle.
      run = 1'b1; tick(); run = 1'b0; tick();
      step = 1'b1; ext = 1'b1; tick(); step = 1'b0; ext = 1'b0;
      check("clr_pre_pulse", 32'(step_out), 32'd1);
      clr = 1'b1; tick(); clr = 1'b0;
      check("clr_state", 32'(state), 32'd0);
      check("clr_count", 32'(count), 32'd0);
      check("clr_pc", 32'(pc), 32'd0);
      check("clr_step", 32'(step_out), 32'd0);
      check("clr_err", 32'(err), 32'd0);
      run = 1'b1; tick(); run = 1'b0;
      check("clr_run_ign", 32'(state), 32'd0);
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_feeder.md
Name: program_feeder

Overview:
- Upstream stage of the processor's external-data tri-state buffer; replaces the raw switches as the source of the processor's input data bus.
- The operator loads a short program (instructions plus immediates) from the switches into a small buffer. The feeder then replays it one word per processor step.
- It generates the processor's step pulse and advances only when the processor actually consumes external data.

Parameters:
WIDTH, 10, data word width (matches processor bus)
DEPTH, 16, program buffer entries
AW, 4, address/counter width, log2(DEPTH)

Ports:
CLK50M  input  1  system clock, 50 MHz, all state changes on rising edge
CLR  input  1  synchronous active-high reset
SW_DATA  input  WIDTH  word to load (switches)
LOAD_STB  input  1  debounced single-cycle pulse: write SW_DATA into buffer
RUN_STB  input  1  debounced single-cycle pulse: start/restart replay
STEP_REQ  input  1  debounced single-cycle pulse: request one processor step
EXT  input  1  processor's external-data enable for the current time step
DONE  input  1  processor's instruction-complete (counter clear) indication
DATA_OUT  output  WIDTH  word presented to the tri-state buffer input
STEP_OUT  output  1  one-cycle step pulse to the processor clock input
PC  output  AW  current read pointer
COUNT  output  AW+1  number of loaded words
STATE  output  2  00 LOAD, 01 RUN, 10 HALT
FULL  output  1  COUNT == DEPTH
EXHAUSTED  output  1  PC == COUNT while in RUN/HALT
ERR  output  1  sticky underflow flag

Behaviour:
- Reset (CLR=1 at an edge): STATE=LOAD, COUNT=0, PC=0, DATA_OUT=0, STEP_OUT=0, FULL=0, EXHAUSTED=0, ERR=0, internal consume flag=0. Buffer contents are not cleared. CLR overrides every other input, including mid-run and mid-pulse; STEP_OUT drops on the next edge.
- LOAD state:
  - LOAD_STB with FULL=0: mem[COUNT]<=SW_DATA, COUNT+1.
  - LOAD_STB with FULL=1: ignored; no wrap, no overwrite.
  - RUN_STB with COUNT>0: go to RUN with PC=0. RUN_STB with COUNT=0 is ignored.
  - LOAD_STB and RUN_STB in the same cycle: the load is performed and RUN_STB is ignored.
  - STEP_REQ is ignored in LOAD. STEP_OUT stays 0 and DATA_OUT stays 0.
- RUN state:
  - DATA_OUT is registered: it equals mem[PC] one cycle after PC changes, or 0 if PC==COUNT.
  - A STEP_REQ is accepted when STEP_OUT=0 and no increment is pending. On acceptance, EXT is captured into the consume flag and STEP_OUT=1 on the next cycle, for exactly one cycle.
  - STEP_REQ during the pulse cycle or the pending-increment cycle is dropped.
  - On the edge that ends the pulse: if the consume flag is 1 and PC<COUNT, PC increments. DATA_OUT updates one cycle later. DATA_OUT is therefore stable for the whole STEP_OUT high cycle.
  - Underflow: if the consume flag is 1 with PC==COUNT, ERR is set (sticky until CLR), PC holds, and the step is still issued with DATA_OUT=0.
  - EXHAUSTED=1 and DONE=1 sampled together at an edge: go to HALT. DONE with EXHAUSTED=0 has no effect.
  - RUN_STB in RUN: restart, PC=0.
- HALT state:
  - STEP_REQ is ignored and STEP_OUT=0.
  - RUN_STB: go to RUN with PC=0, replaying the same program.
  - LOAD_STB: go to LOAD with COUNT=0, PC=0, and no write on that cycle.
  - LOAD_STB and RUN_STB together: LOAD wins.
- Widths: COUNT is AW+1 bits so that COUNT==DEPTH is representable. PC never exceeds COUNT.

Test Plan:
- CLR, then 3 LOAD_STB with SW_DATA=0x040,0x005,0x123 -> COUNT=3, STATE=00, FULL=0, DATA_OUT=0, STEP_OUT never asserted.
- Load 3 words, RUN_STB, then STEP_REQ with EXT=1 -> STEP_OUT high exactly 1 cycle later with DATA_OUT=0x040. PC=1 one cycle after the pulse, and DATA_OUT=0x005 one cycle after that.
- In RUN, STEP_REQ with EXT=0 -> STEP_OUT pulses, and PC and DATA_OUT are unchanged. A STEP_REQ on the pulse cycle is dropped, giving a single pulse.
- Consume all 3 words, then assert DONE -> STATE=10 and EXHAUSTED=1. STEP_REQ gives no pulse. RUN_STB gives STATE=01, PC=0, DATA_OUT=0x040.
- Load 16 words, then a 17th LOAD_STB with 0x3FF -> FULL=1, COUNT=16, mem[0] unchanged. In RUN with 16 consumed, a STEP_REQ with EXT=1 gives ERR=1 and DATA_OUT=0 during the pulse.
- Assert CLR mid-RUN on the STEP_OUT cycle -> next cycle STATE=00, COUNT=0, PC=0, STEP_OUT=0, ERR=0. RUN_STB immediately after is ignored (COUNT=0).
